// File: rtl/dino_pkg.sv
// Shared types and constants for the obstacle field: FSM states, LFSR seed/taps,
// default sprite size and a small range helper used by the sprite ROM.
package dino_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        CRASH = 2'd2
    } state_e;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    localparam int SPR_W_DEF = 60;
    localparam int SPR_H_DEF = 58;

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return {v[14:0], ^(v & LFSR_TAPS)};
    endfunction

    function automatic logic in_rng(input int v, input int lo, input int hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/obstacle_sprite_rom.sv
// Combinational cactus bitmap; bit index = x + y*SPR_W with bit 0 at the top-left.
module obstacle_sprite_rom
    import dino_pkg::*;
#(
    parameter int  SPR_W = SPR_W_DEF,
    parameter int  SPR_H = SPR_H_DEF,
    localparam int IDX_W = $clog2(SPR_W * SPR_H)
) (
    input  logic [IDX_W-1:0] addr,
    output logic             data
);

    int x_s;
    int y_s;

    // Decode the linear index into x/y and test it against the cactus shape
    always_comb begin
        y_s = int'(addr) / SPR_W;
        x_s = int'(addr) % SPR_W;
        if (y_s >= SPR_H) begin
            data = 1'b0;
        end else begin
            data = in_rng(x_s, 24, 35)
                 | (in_rng(x_s, 6, 11)  & in_rng(y_s, 10, 35))
                 | (in_rng(x_s, 6, 23)  & in_rng(y_s, 30, 35))
                 | (in_rng(x_s, 48, 53) & in_rng(y_s, 5, 30))
                 | (in_rng(x_s, 36, 53) & in_rng(y_s, 25, 30));
        end
    end

endmodule

// File: rtl/obstacle_field.sv
// Scrolling obstacle slots with LFSR-spaced spawning and a registered pixel output.
// Optional collision detection is enabled by defining OBSTACLE_COLLIDE_EN.
module obstacle_field
    import dino_pkg::*;
#(
    parameter int  N_OBS    = 3,
    parameter int  SPR_W    = SPR_W_DEF,
    parameter int  SPR_H    = SPR_H_DEF,
    parameter int  Y_TOP    = 344,
    parameter int  H_VIS    = 640,
    parameter int  MIN_GAP  = 40,
    parameter int  GAP_MASK = 63,
    localparam int CNT_W    = $clog2(N_OBS + 1)
) (
    input  logic             clk,
    input  logic             RESET,
    input  logic             START,
    input  logic             game_status,
    input  logic             fresh,
    input  logic [3:0]       speed,
    input  logic [8:0]       row_addr,
    input  logic [9:0]       col_addr,
    input  logic             dino_px,
    output logic             px,
    output logic             hit,
    output logic [CNT_W-1:0] pass_cnt
);

    localparam int          IDX_W      = $clog2(SPR_W * SPR_H);
    localparam logic [11:0] HVIS_C     = 12'(H_VIS);
    localparam logic [11:0] HEND_C     = 12'(H_VIS + SPR_W);
    localparam logic [11:0] YTOP_C     = 12'(Y_TOP);
    localparam logic [11:0] YEND_C     = 12'(Y_TOP + SPR_H);
    localparam logic [15:0] MIN_GAP_C  = 16'(MIN_GAP);
    localparam logic [15:0] GAP_MASK_C = 16'(GAP_MASK);
    localparam logic [15:0] SPR_W_C    = 16'(SPR_W);

    state_e             state_r, next_state_s;
    logic               fresh_q_r, tick_s, tick_run_s, enter_run_s;
    logic [N_OBS-1:0]   active_r, retire_s, free_s, spawn_s, in_s, rom_bit_s;
    logic [10:0]        pos_r [N_OBS];
    logic [11:0]        sum_s [N_OBS];
    logic [11:0]        sx_s  [N_OBS];
    logic [IDX_W-1:0]   idx_s [N_OBS];
    logic [11:0]        row_s;
    logic               found_s, spawn_due_s, px_r, hit_r, hit_set_s;
    logic [CNT_W-1:0]   retire_cnt_s, pass_cnt_r;
    logic [15:0]        gap_r, gap_dec_s, reload_s, lfsr_r;

    assign tick_s     = fresh_q_r & ~fresh;
    assign tick_run_s = tick_s & (state_r == RUN);

    // Frame strobe delay for falling-edge detection
    always_ff @(posedge clk) begin
        if (RESET) fresh_q_r <= 1'b0;
        else       fresh_q_r <= fresh;
    end

    // Next-state decode; entering RUN from any other state restarts the run
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE:    if (START) next_state_s = RUN;   else next_state_s = IDLE;
            RUN:     if (!game_status || hit_set_s) next_state_s = CRASH; else next_state_s = RUN;
            CRASH:   if (START) next_state_s = RUN;   else next_state_s = CRASH;
            default: next_state_s = IDLE;
        endcase
        enter_run_s = (state_r != RUN) && (next_state_s == RUN);
    end

    // State register
    always_ff @(posedge clk) begin
        if (RESET) state_r <= IDLE;
        else       state_r <= next_state_s;
    end

    // Per-slot motion, retirement and lowest-free spawn selection
    always_comb begin
        retire_cnt_s = '0;
        found_s      = 1'b0;
        for (int i = 0; i < N_OBS; i++) begin
            sum_s[i]    = {1'b0, pos_r[i]} + {8'd0, speed};
            retire_s[i] = active_r[i] & (sum_s[i] >= HEND_C);
            free_s[i]   = ~active_r[i] | retire_s[i];
            retire_cnt_s = retire_cnt_s + CNT_W'(retire_s[i]);
            if (free_s[i] && !found_s) begin
                spawn_s[i] = 1'b1;
                found_s    = 1'b1;
            end else begin
                spawn_s[i] = 1'b0;
            end
        end
        gap_dec_s   = (gap_r == 16'd0) ? 16'd0 : gap_r - 16'd1;
        spawn_due_s = (gap_dec_s == 16'd0);
        reload_s    = MIN_GAP_C + (lfsr_r & GAP_MASK_C);
    end

    // Slot, gap counter, LFSR and retire-count registers
    always_ff @(posedge clk) begin
        if (RESET) begin
            active_r   <= '0;
            for (int i = 0; i < N_OBS; i++) pos_r[i] <= 11'd0;
            gap_r      <= MIN_GAP_C;
            lfsr_r     <= LFSR_SEED;
            pass_cnt_r <= '0;
        end else if (enter_run_s) begin
            active_r   <= '0;
            for (int i = 0; i < N_OBS; i++) pos_r[i] <= 11'd0;
            gap_r      <= MIN_GAP_C;
            pass_cnt_r <= '0;
        end else if (tick_run_s) begin
            for (int i = 0; i < N_OBS; i++) begin
                if (spawn_due_s && spawn_s[i]) begin
                    active_r[i] <= 1'b1;
                    pos_r[i]    <= 11'd0;
                end else if (retire_s[i]) begin
                    active_r[i] <= 1'b0;
                end else if (active_r[i]) begin
                    pos_r[i]    <= sum_s[i][10:0];
                end else begin
                    pos_r[i]    <= pos_r[i];
                end
            end
            // With every slot busy the counter parks at zero and retries next tick
            if (spawn_due_s) gap_r <= found_s ? reload_s : 16'd0;
            else             gap_r <= gap_dec_s;
            lfsr_r     <= lfsr_next(lfsr_r);
            pass_cnt_r <= retire_cnt_s;
        end else begin
            pass_cnt_r <= '0;
        end
    end

    // Sprite window test and ROM address for each slot
    always_comb begin
        row_s = {3'd0, row_addr};
        for (int i = 0; i < N_OBS; i++) begin
            sx_s[i]  = {2'd0, col_addr} + {1'b0, pos_r[i]};
            in_s[i]  = active_r[i] & (row_s >= YTOP_C) & (row_s < YEND_C)
                     & (sx_s[i] >= HVIS_C) & (sx_s[i] < HEND_C);
            idx_s[i] = IDX_W'(16'(sx_s[i] - HVIS_C) + 16'(row_s - YTOP_C) * SPR_W_C);
        end
    end

    for (genvar g = 0; g < N_OBS; g++) begin : g_slot
        obstacle_sprite_rom #(.SPR_W(SPR_W), .SPR_H(SPR_H)) u_rom (
            .addr (idx_s[g]),
            .data (rom_bit_s[g])
        );
    end

    // Registered pixel; blank while idle, frozen slots stay visible after a crash
    always_ff @(posedge clk) begin
        if (RESET)                px_r <= 1'b0;
        else if (state_r == IDLE) px_r <= 1'b0;
        else                      px_r <= |(in_s & rom_bit_s);
    end

`ifdef OBSTACLE_COLLIDE_EN
    logic dino_q_r;

    // Dinosaur pixel delayed to line up with the registered obstacle pixel
    always_ff @(posedge clk) begin
        if (RESET) dino_q_r <= 1'b0;
        else       dino_q_r <= dino_px;
    end

    assign hit_set_s = (state_r == RUN) & px_r & dino_q_r;
`else
    logic unused_dino_s;
    assign unused_dino_s = dino_px;
    assign hit_set_s     = 1'b0;
`endif

    // Sticky collision flag, cleared when a new run begins
    always_ff @(posedge clk) begin
        if (RESET)            hit_r <= 1'b0;
        else if (enter_run_s) hit_r <= 1'b0;
        else if (hit_set_s)   hit_r <= 1'b1;
        else                  hit_r <= hit_r;
    end

    assign px       = px_r;
    assign hit      = hit_r;
    assign pass_cnt = pass_cnt_r;

endmodule

// File: tb/tb_obstacle_field.sv
// Directed bench for obstacle_field: spawn timing, drawing, retirement, deferred
// spawn on a single-slot instance, crash freeze and mid-run reset.
module tb_obstacle_field;
    import dino_pkg::*;

    logic       clk = 1'b0;
    logic       RESET, START, game_status, fresh, dino_px;
    logic [3:0] speed;
    logic [8:0] row_addr;
    logic [9:0] col_addr;
    logic       px, hit;
    logic [1:0] pass_cnt;
    logic       reset2, start2;
    logic [3:0] speed2;
    logic       px2, hit2;
    logic [0:0] pass2;
    int         total = 0;
    int         bad = 0;

    always #5 clk = ~clk;

    obstacle_field dut (
        .clk(clk), .RESET(RESET), .START(START), .game_status(game_status), .fresh(fresh),
        .speed(speed), .row_addr(row_addr), .col_addr(col_addr), .dino_px(dino_px),
        .px(px), .hit(hit), .pass_cnt(pass_cnt)
    );

    obstacle_field #(.N_OBS(1), .MIN_GAP(1), .GAP_MASK(0)) dut2 (
        .clk(clk), .RESET(reset2), .START(start2), .game_status(game_status), .fresh(fresh),
        .speed(speed2), .row_addr(row_addr), .col_addr(col_addr), .dino_px(dino_px),
        .px(px2), .hit(hit2), .pass_cnt(pass2)
    );

    task automatic tick();
        @(negedge clk) fresh = 1'b1;
        @(negedge clk) fresh = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_start();
        @(negedge clk) START = 1'b1;
        @(negedge clk) START = 1'b0;
    endtask

    task automatic test_reset();
        RESET = 1'b1; reset2 = 1'b1;
        repeat (2) @(negedge clk);
        RESET = 1'b0; reset2 = 1'b0;
        total++; if (px !== 1'b0) begin bad++; $display("FAIL reset_px: got %0b want 0", px); end
        total++; if (hit !== 1'b0) begin bad++; $display("FAIL reset_hit: got %0b want 0", hit); end
        total++; if (pass_cnt !== 2'd0) begin bad++; $display("FAIL reset_pass: got %0d want 0", pass_cnt); end
        total++; if (dut.state_r !== IDLE) begin bad++; $display("FAIL reset_state: got %0d want IDLE", dut.state_r); end
        total++; if (dut.lfsr_r !== 16'hACE1) begin bad++; $display("FAIL reset_lfsr: got %h want ace1", dut.lfsr_r); end
        total++; if (dut.gap_r !== 16'd40) begin bad++; $display("FAIL reset_gap: got %0d want 40", dut.gap_r); end
        total++; if (dut.active_r !== 3'b000) begin bad++; $display("FAIL reset_active: got %b want 000", dut.active_r); end
        tick();
        total++; if (dut.lfsr_r !== 16'hACE1) begin bad++; $display("FAIL idle_lfsr: got %h want ace1", dut.lfsr_r); end
    endtask

    task automatic test_deferred_spawn();
        @(negedge clk) start2 = 1'b1;
        @(negedge clk) start2 = 1'b0;
        total++; if (dut2.state_r !== RUN) begin bad++; $display("FAIL def_state: got %0d want RUN", dut2.state_r); end
        tick();
        total++; if (dut2.active_r !== 1'b1 || dut2.pos_r[0] !== 11'd0) begin bad++;
            $display("FAIL def_spawn: got act=%b pos=%0d want act=1 pos=0", dut2.active_r, dut2.pos_r[0]); end
        tick();
        total++; if (dut2.gap_r !== 16'd0 || dut2.pos_r[0] !== 11'd1) begin bad++;
            $display("FAIL def_hold: got gap=%0d pos=%0d want gap=0 pos=1", dut2.gap_r, dut2.pos_r[0]); end
        for (int t = 2; t < 700; t++) tick();
        total++; if (dut2.gap_r !== 16'd0 || dut2.pos_r[0] !== 11'd699 || pass2 !== 1'b0) begin bad++;
            $display("FAIL def_busy: got gap=%0d pos=%0d pass=%0d want 0/699/0", dut2.gap_r, dut2.pos_r[0], pass2); end
        tick();
        total++; if (pass2 !== 1'b1 || dut2.active_r !== 1'b1 || dut2.pos_r[0] !== 11'd0 || dut2.gap_r !== 16'd1) begin bad++;
            $display("FAIL def_retire_spawn: got pass=%0d act=%b pos=%0d gap=%0d want 1/1/0/1",
                     pass2, dut2.active_r, dut2.pos_r[0], dut2.gap_r); end
        @(negedge clk);
        total++; if (pass2 !== 1'b0) begin bad++; $display("FAIL def_pass_width: got %0d want 0", pass2); end
    endtask

    task automatic test_spawn();
        speed = 4'd4;
        pulse_start();
        total++; if (dut.state_r !== RUN || dut.gap_r !== 16'd40) begin bad++;
            $display("FAIL run_entry: got state=%0d gap=%0d want RUN/40", dut.state_r, dut.gap_r); end
        tick();
        total++; if (dut.lfsr_r !== 16'h59C3) begin bad++; $display("FAIL lfsr_step: got %h want 59c3", dut.lfsr_r); end
        for (int k = 2; k < 40; k++) tick();
        total++; if (dut.active_r !== 3'b000 || dut.gap_r !== 16'd1) begin bad++;
            $display("FAIL pre_spawn: got act=%b gap=%0d want 000/1", dut.active_r, dut.gap_r); end
        tick();
        total++; if (dut.active_r !== 3'b001 || dut.pos_r[0] !== 11'd0) begin bad++;
            $display("FAIL spawn40: got act=%b pos=%0d want 001/0", dut.active_r, dut.pos_r[0]); end
        for (int k = 41; k <= 45; k++) tick();
        total++; if (dut.pos_r[0] !== 11'd20) begin bad++; $display("FAIL pos45: got %0d want 20", dut.pos_r[0]); end
    endtask

    task automatic test_pixels();
        int rows[10] = '{344, 344, 344, 344, 343, 354, 354, 401, 402, 349};
        int cols[10] = '{643, 644, 655, 656, 650, 630, 640, 650, 650, 670};
        int exps[10] = '{0, 1, 1, 0, 0, 1, 0, 1, 0, 1};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk) begin row_addr = 9'(rows[i]); col_addr = 10'(cols[i]); end
            @(negedge clk);
            total++; if (px !== 1'(exps[i])) begin bad++;
                $display("FAIL pixel r%0d c%0d: got %0b want %0d", rows[i], cols[i], px, exps[i]); end
        end
    endtask

    task automatic test_speed0_long_fresh();
        speed = 4'd0;
        tick(); tick();
        total++; if (dut.pos_r[0] !== 11'd20) begin bad++; $display("FAIL speed0: got %0d want 20", dut.pos_r[0]); end
        speed = 4'd4;
        @(negedge clk) fresh = 1'b1;
        @(negedge clk) fresh = 1'b0;
        repeat (100) @(negedge clk);
        total++; if (dut.pos_r[0] !== 11'd24) begin bad++; $display("FAIL long_fresh: got %0d want 24", dut.pos_r[0]); end
    endtask

    task automatic test_retire_reuse();
        int  pos_m = 24;
        bit  seen = 1'b0;
        int  n = 0;
        speed = 4'd15;
        for (int i = 0; i < 60 && !seen; i++) begin
            tick();
            pos_m += 15;
            if (pos_m >= 700) begin
                seen = 1'b1;
                total++; if (pass_cnt !== 2'd1) begin bad++; $display("FAIL retire_pass: got %0d want 1", pass_cnt); end
                @(negedge clk);
                total++; if (pass_cnt !== 2'd0) begin bad++; $display("FAIL retire_pulse: got %0d want 0", pass_cnt); end
            end else begin
                total++; if (pass_cnt !== 2'd0 || dut.pos_r[0] !== 11'(pos_m)) begin bad++;
                    $display("FAIL move15: got pass=%0d pos=%0d want 0/%0d", pass_cnt, dut.pos_r[0], pos_m); end
            end
        end
        if (!seen) begin total++; bad++; $display("FAIL retire_timeout: got none want retire"); end
        while (!dut.active_r[0] && n < 150) begin tick(); n++; end
        total++; if (dut.active_r[0] !== 1'b1 || dut.pos_r[0] !== 11'd0 || dut.active_r[2] !== 1'b0) begin bad++;
            $display("FAIL reuse: got act=%b pos=%0d want slot0 reused at 0", dut.active_r, dut.pos_r[0]); end
    endtask

    task automatic test_crash_freeze();
        speed = 4'd4;
        @(negedge clk) begin game_status = 1'b0; row_addr = 9'd344; col_addr = 10'd664; end
        @(negedge clk);
        total++; if (dut.state_r !== CRASH) begin bad++; $display("FAIL crash_state: got %0d want CRASH", dut.state_r); end
        tick();
        total++; if (dut.pos_r[0] !== 11'd0) begin bad++; $display("FAIL crash_freeze: got %0d want 0", dut.pos_r[0]); end
        total++; if (px !== 1'b1) begin bad++; $display("FAIL crash_draw: got %0b want 1", px); end
        game_status = 1'b1;
        pulse_start();
        total++; if (dut.state_r !== RUN || dut.active_r !== 3'b000 || hit !== 1'b0) begin bad++;
            $display("FAIL restart: got state=%0d act=%b hit=%0b want RUN/000/0", dut.state_r, dut.active_r, hit); end
        @(negedge clk);
        total++; if (px !== 1'b0) begin bad++; $display("FAIL restart_px: got %0b want 0", px); end
    endtask

    task automatic test_collide();
        for (int k = 0; k < 40; k++) tick();
        @(negedge clk) dino_px = 1'b1;
        @(negedge clk);
        total++; if (px !== 1'b1) begin bad++; $display("FAIL overlap_px: got %0b want 1", px); end
        @(negedge clk) dino_px = 1'b0;
`ifdef OBSTACLE_COLLIDE_EN
        total++; if (hit !== 1'b1 || dut.state_r !== CRASH) begin bad++;
            $display("FAIL collide: got hit=%0b state=%0d want 1/CRASH", hit, dut.state_r); end
        tick();
        total++; if (dut.pos_r[0] !== 11'd0) begin bad++; $display("FAIL collide_freeze: got %0d want 0", dut.pos_r[0]); end
        pulse_start();
        total++; if (hit !== 1'b0 || dut.active_r !== 3'b000) begin bad++;
            $display("FAIL collide_restart: got hit=%0b act=%b want 0/000", hit, dut.active_r); end
`else
        total++; if (hit !== 1'b0 || dut.state_r !== RUN) begin bad++;
            $display("FAIL no_collide: got hit=%0b state=%0d want 0/RUN", hit, dut.state_r); end
`endif
    endtask

    task automatic test_reset_mid_run();
        int n = 0;
        speed = 4'd4;
        while ($countones(dut.active_r) < 2 && n < 250) begin tick(); n++; end
        total++; if ($countones(dut.active_r) !== 2) begin bad++;
            $display("FAIL two_active: got %b want two slots", dut.active_r); end
        @(negedge clk) fresh = 1'b1;
        @(negedge clk) begin fresh = 1'b0; RESET = 1'b1; end
        @(negedge clk) RESET = 1'b0;
        total++; if (px !== 1'b0 || pass_cnt !== 2'd0) begin bad++;
            $display("FAIL mid_reset_out: got px=%0b pass=%0d want 0/0", px, pass_cnt); end
        total++; if (dut.state_r !== IDLE || dut.lfsr_r !== 16'hACE1 || dut.active_r !== 3'b000) begin bad++;
            $display("FAIL mid_reset_state: got state=%0d lfsr=%h act=%b want IDLE/ace1/000",
                     dut.state_r, dut.lfsr_r, dut.active_r); end
    endtask

    initial begin
        RESET = 1'b1; START = 1'b0; game_status = 1'b1; fresh = 1'b0; dino_px = 1'b0;
        speed = 4'd0; row_addr = 9'd0; col_addr = 10'd0;
        reset2 = 1'b1; start2 = 1'b0; speed2 = 4'd1;
        test_reset();
        test_deferred_spawn();
        test_spawn();
        test_pixels();
        test_speed0_long_fresh();
        test_retire_reuse();
        test_crash_freeze();
        test_collide();
        test_reset_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout want completion (total=%0d bad=%0d)", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/obstacle_field.md
OBSTACLE_FIELD -- requirements
Module: obstacle_field

Interface
REQ-001 Parameter N_OBS, default 3, number of obstacle slots (1..8).
REQ-002 Parameter SPR_W, default 60, sprite width in pixels.
REQ-003 Parameter SPR_H, default 58, sprite height in pixels.
REQ-004 Parameter Y_TOP, default 344, first sprite row on screen.
REQ-005 Parameter H_VIS, default 640, visible line width.
REQ-006 Parameter MIN_GAP, default 40, minimum number of frames between spawns.
REQ-007 Parameter GAP_MASK, default 63, mask applied to the LFSR for the extra random gap.
REQ-008 Port clk  in  1  pixel clock; all logic on its rising edge.
REQ-009 Port RESET  in  1  synchronous, active-high reset.
REQ-010 Port START  in  1  level; starts or restarts a run.
REQ-011 Port game_status  in  1  level; 1 = game running.
REQ-012 Port fresh  in  1  frame strobe; each falling edge, sampled on clk, is one frame tick.
REQ-013 Port speed  in  4  pixels moved per frame tick.
REQ-014 Port row_addr  in  9  current scan row.
REQ-015 Port col_addr  in  10  current scan column.
REQ-016 Port dino_px  in  1  dinosaur pixel for the same row/col.
REQ-017 Port px  out  1  registered obstacle pixel.
REQ-018 Port hit  out  1  sticky collision flag.
REQ-019 Port pass_cnt  out  $clog2(N_OBS+1)  obstacles retired this tick; valid for one cycle.

Function
REQ-020 Frame tick: tick = fresh_q & ~fresh, with fresh_q registered on clk; tick is one cycle wide.
REQ-021 FSM states: IDLE, RUN, CRASH; the reset state is IDLE.
REQ-022 IDLE->RUN on START; RUN->CRASH when game_status=0 or hit rises; CRASH->RUN on START.
REQ-023 Entering RUN clears all slots, loads the gap counter with MIN_GAP and clears hit.
REQ-024 Each slot holds active (1b) and pos (11b); screen x = H_VIS - pos.
REQ-025 On tick in RUN, each active slot sets pos <= pos + speed; when speed=0 pos holds.
REQ-026 A slot retires (active<=0) on the tick where pos + speed >= H_VIS + SPR_W; pass_cnt equals the number of slots retired on that tick.
REQ-027 Gap counter decrements on each tick in RUN; at 0 the lowest-index free slot activates with pos=0, and the counter reloads with MIN_GAP + (lfsr & GAP_MASK).
REQ-028 No free slot at gap 0: the counter holds 0 and spawn is retried on the next tick.
REQ-029 Slots retiring on a tick count as free for a spawn on that same tick.
REQ-030 LFSR: 16-bit Fibonacci, taps 16,14,13,11, seed 16'hACE1; steps once per tick in RUN and never reaches zero.
REQ-031 A slot draws a pixel when Y_TOP <= row_addr < Y_TOP+SPR_H and H_VIS <= col_addr+pos < H_VIS+SPR_W.
REQ-032 Sprite bit index = (col_addr+pos-H_VIS) + (row_addr-Y_TOP)*SPR_W; bit 0 is the top-left pixel.
REQ-033 px = OR of all slot pixels, registered; latency is 1 clk from row/col.
REQ-034 In IDLE, px=0; in CRASH, positions freeze and are still drawn.
REQ-035 All intermediate arithmetic is at least 12 bits wide, so pos+speed and col_addr+pos never wrap.

Reset
REQ-036 RESET is synchronous, active-high and overrides START and tick.
REQ-037 RESET drives px=0, hit=0, pass_cnt=0, all slots inactive, pos=0, lfsr=16'hACE1, gap=MIN_GAP and state IDLE.
REQ-038 RESET asserted mid-run takes effect on the next clk edge, with no pass_cnt pulse.

Configuration
REQ-039 Macro OBSTACLE_COLLIDE_EN defined: hit sets when registered px & dino_px (dino_px delayed 1 clk for alignment) while in RUN, and the FSM goes RUN->CRASH.
REQ-040 Macro OBSTACLE_COLLIDE_EN undefined: hit is tied 0, dino_px is ignored, and CRASH is entered only via game_status=0.

Structure
REQ-041 Package dino_pkg holds the state enum (IDLE/RUN/CRASH), LFSR seed/taps and default sprite dimensions.
REQ-042 Sub-module obstacle_sprite_rom (combinational, SPR_W*SPR_H bits, indexed per REQ-032) is instantiated once per slot.

Verification
REQ-043 RESET, START, speed=4, 45 ticks -> slot0 spawns on tick 40; pos=20 after tick 45; px=1 at row 344 only on columns with sprite bit set, 1 clk later.
REQ-044 speed=15, one obstacle -> retires on the tick where pos+15 >= 700; pass_cnt=1 for exactly one clk; slot reused on the next spawn.
REQ-045 N_OBS=1, MIN_GAP=1, GAP_MASK=0, speed=1 -> spawn is deferred while the slot is busy; the gap counter holds 0 and spawn occurs on the retire tick.
REQ-046 With OBSTACLE_COLLIDE_EN, dino_px=1 overlapping an obstacle pixel -> hit=1 the next clk, state CRASH, pos frozen; START -> hit=0 and slots cleared.
REQ-047 RESET asserted mid-run with 2 active slots -> next clk px=0, pass_cnt=0, state IDLE, lfsr=16'hACE1.
REQ-048 fresh held low for 100 clk -> exactly one tick; speed=0 -> pos unchanged across ticks.
